// File: rtl/merge_chunk_feeder_if.sv
// AXI-stream style bundle between the chunk feeder, its source and the merger.
// The master drives payload, valid and tlast; the slave drives ready.
interface axi_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 32,
    parameter int USER_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
    logic                  valid;
    logic                  ready;
    logic                  tlast;

    modport master (
        output data, dest, user, valid, tlast,
        input  ready
    );

    modport slave (
        input  data, dest, user, valid, tlast,
        output ready
    );
endinterface

// File: rtl/merge_chunk_feeder.sv
// Captures two sorted runs from one stream and replays them as runs A/B to the merger.
// Define CHUNK_FEEDER_ORDER_CHECK_EN to flag runs whose data is not non-decreasing.
module merge_chunk_feeder #(
    parameter int  DATA_WIDTH      = 32,
    parameter int  DEST_WIDTH      = 32,
    parameter int  USER_WIDTH      = 32,
    parameter int  MAX_SORT_LENGTH = 32,
    localparam int SW              = $clog2(MAX_SORT_LENGTH),
    localparam int WW              = DATA_WIDTH + DEST_WIDTH + USER_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    axi_stream.slave      data_in,
    input  logic          flush,
    axi_stream.master     chunk_a,
    axi_stream.master     chunk_b,
    output logic [SW-1:0] chunk_a_size,
    output logic [SW-1:0] chunk_b_size,
    output logic          start,
    input  logic          merge_done,
    output logic          overflow,
    output logic          order_error
);

    typedef enum logic [1:0] {
        FILL_A,
        FILL_B,
        ISSUE,
        DRAIN
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [SW-1:0] r_wr_ptr;
    logic [SW-1:0] r_rd_a;
    logic [SW-1:0] r_rd_b;
    logic [SW-1:0] r_size_a;
    logic [SW-1:0] r_size_b;
    logic          r_overflow;

    logic [WW-1:0] r_buf_a [MAX_SORT_LENGTH];
    logic [WW-1:0] r_buf_b [MAX_SORT_LENGTH];

    logic          w_fill;
    logic          w_ready;
    logic          w_hs;
    logic          w_last_slot;
    logic          w_split;
    logic          w_close;
    logic          w_flush_idle;
    logic          w_drain;
    logic          w_va;
    logic          w_vb;
    logic [SW-1:0] w_ptr_inc;
    logic [WW-1:0] w_in_word;
    logic [WW-1:0] w_word_a;
    logic [WW-1:0] w_word_b;

    // A run is closed by tlast or when it would otherwise outgrow the buffer.
    always_comb begin
        w_fill       = (r_state == FILL_A) || (r_state == FILL_B);
        w_ready      = w_fill & reset;
        w_hs         = w_ready & data_in.valid;
        w_last_slot  = (r_wr_ptr == SW'(MAX_SORT_LENGTH - 2));
        w_split      = w_hs & ~data_in.tlast & w_last_slot;
        w_close      = w_hs & (data_in.tlast | w_last_slot);
        w_flush_idle = flush & ~w_hs;
        w_ptr_inc    = r_wr_ptr + 1'b1;
        w_in_word    = {data_in.data, data_in.dest, data_in.user};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FILL_A: begin
                if (w_close && flush) begin
                    w_next = ISSUE;
                end else if (w_close) begin
                    w_next = FILL_B;
                end else if (w_flush_idle && r_wr_ptr != '0) begin
                    w_next = ISSUE;
                end
            end
            FILL_B: begin
                if (w_close || w_flush_idle) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                w_next = DRAIN;
            end
            DRAIN: begin
                if (merge_done) begin
                    w_next = FILL_A;
                end
            end
            default: begin
                w_next = FILL_A;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= FILL_A;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_a     <= '0;
            r_rd_b     <= '0;
            r_size_a   <= '0;
            r_size_b   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow | w_split;
            case (r_state)
                FILL_A: begin
                    if (w_hs) begin
                        r_wr_ptr <= w_close ? '0 : w_ptr_inc;
                    end
                    // A flush that closes a lone A run issues it with an empty B.
                    if (w_close) begin
                        r_size_a <= w_ptr_inc;
                        if (flush) begin
                            r_size_b <= '0;
                        end
                    end else if (w_flush_idle && r_wr_ptr != '0) begin
                        r_size_a <= r_wr_ptr;
                        r_size_b <= '0;
                        r_wr_ptr <= '0;
                    end
                end
                FILL_B: begin
                    if (w_hs) begin
                        r_wr_ptr <= w_close ? '0 : w_ptr_inc;
                    end
                    if (w_close) begin
                        r_size_b <= w_ptr_inc;
                    end else if (w_flush_idle) begin
                        r_size_b <= r_wr_ptr;
                        r_wr_ptr <= '0;
                    end
                end
                ISSUE: begin
                    r_rd_a <= '0;
                    r_rd_b <= '0;
                end
                DRAIN: begin
                    if (w_va && chunk_a.ready) begin
                        r_rd_a <= r_rd_a + 1'b1;
                    end
                    if (w_vb && chunk_b.ready) begin
                        r_rd_b <= r_rd_b + 1'b1;
                    end
                    if (merge_done) begin
                        r_wr_ptr <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_hs && r_state == FILL_A) begin
            r_buf_a[r_wr_ptr] <= w_in_word;
        end
        if (w_hs && r_state == FILL_B) begin
            r_buf_b[r_wr_ptr] <= w_in_word;
        end
    end

`ifdef CHUNK_FEEDER_ORDER_CHECK_EN
    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_order_err;

    // The first word of each run has nothing to be compared against.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev      <= '0;
            r_order_err <= 1'b0;
        end else if (w_hs) begin
            r_prev <= data_in.data;
            if (r_wr_ptr != '0 && data_in.data < r_prev) begin
                r_order_err <= 1'b1;
            end
        end
    end

    assign order_error = r_order_err;
`else
    assign order_error = 1'b0;
`endif

    always_comb begin
        w_drain  = (r_state == DRAIN);
        w_va     = w_drain & (r_rd_a < r_size_a);
        w_vb     = w_drain & (r_rd_b < r_size_b);
        w_word_a = r_buf_a[r_rd_a];
        w_word_b = r_buf_b[r_rd_b];
    end

    assign data_in.ready = w_ready;

    assign chunk_a.valid = w_va;
    assign chunk_a.tlast = w_va & (r_rd_a == r_size_a - 1'b1);
    assign {chunk_a.data, chunk_a.dest, chunk_a.user} = w_drain ? w_word_a : '0;

    assign chunk_b.valid = w_vb;
    assign chunk_b.tlast = w_vb & (r_rd_b == r_size_b - 1'b1);
    assign {chunk_b.data, chunk_b.dest, chunk_b.user} = w_drain ? w_word_b : '0;

    assign chunk_a_size = r_size_a;
    assign chunk_b_size = r_size_b;
    assign start        = (r_state == ISSUE);
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_merge_chunk_feeder.sv
// Bench for merge_chunk_feeder: directed cases and random run pairs checked
// against a queue model of how words are grouped into runs A and B.
module tb_merge_chunk_feeder;
    localparam int DW   = 16;
    localparam int EW   = 8;
    localparam int UW   = 8;
    localparam int MAXL = 8;
    localparam int SW   = $clog2(MAXL);

    typedef logic [31:0] word_t;

    logic          clock      = 1'b0;
    logic          reset      = 1'b0;
    logic          flush      = 1'b0;
    logic          merge_done = 1'b0;
    logic [SW-1:0] a_size;
    logic [SW-1:0] b_size;
    logic          start;
    logic          overflow;
    logic          order_error;

    int checks = 0;
    int errors = 0;

    axi_stream #(.DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW)) din ();
    axi_stream #(.DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW)) ca ();
    axi_stream #(.DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW)) cb ();

    merge_chunk_feeder #(
        .DATA_WIDTH(DW),
        .DEST_WIDTH(EW),
        .USER_WIDTH(UW),
        .MAX_SORT_LENGTH(MAXL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .data_in(din),
        .flush(flush),
        .chunk_a(ca),
        .chunk_b(cb),
        .chunk_a_size(a_size),
        .chunk_b_size(b_size),
        .start(start),
        .merge_done(merge_done),
        .overflow(overflow),
        .order_error(order_error)
    );

    always #5 clock = ~clock;

    // Model: runs collected so far, which run is filling, sticky flags.
    word_t qa[$];
    word_t qb[$];
    int    phase;
    bit    exp_ovf;
    bit    exp_oe;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic word_t mk(logic [15:0] d);
        return {d, d[7:0] ^ 8'h3C, d[15:8] + 8'h11};
    endfunction

    task automatic model_take(word_t w, bit last);
        word_t p;
        if (phase == 0) begin
`ifdef CHUNK_FEEDER_ORDER_CHECK_EN
            if (qa.size() > 0) begin
                p = qa[qa.size()-1];
                if (w[31:16] < p[31:16]) exp_oe = 1;
            end
`endif
            qa.push_back(w);
            if (last || qa.size() == MAXL - 1) begin
                if (!last) exp_ovf = 1;
                phase = 1;
            end
        end else begin
`ifdef CHUNK_FEEDER_ORDER_CHECK_EN
            if (qb.size() > 0) begin
                p = qb[qb.size()-1];
                if (w[31:16] < p[31:16]) exp_oe = 1;
            end
`endif
            qb.push_back(w);
            if (last || qb.size() == MAXL - 1) begin
                if (!last) exp_ovf = 1;
                phase = 2;
            end
        end
    endtask

    task automatic push(word_t w, bit last, bit fl);
        din.valid = 1'b1;
        {din.data, din.dest, din.user} = w;
        din.tlast = last;
        flush = fl;
        @(negedge clock);
        chk("in_ready", din.ready, 1);
        @(posedge clock);
        #1;
        din.valid = 1'b0;
        din.tlast = 1'b0;
        flush = 1'b0;
        model_take(w, last);
    endtask

    task automatic idle(bit fl, bit md);
        flush = fl;
        merge_done = md;
        @(negedge clock);
        chk("idle_ready", din.ready, 1);
        @(posedge clock);
        #1;
        flush = 1'b0;
        merge_done = 1'b0;
        if (fl && phase == 1) phase = 2;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        chk("rst_ready", din.ready, 0);
        chk("rst_a_valid", ca.valid, 0);
        chk("rst_b_valid", cb.valid, 0);
        chk("rst_start", start, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_order_err", order_error, 0);
        qa.delete();
        qb.delete();
        phase = 0;
        exp_ovf = 0;
        exp_oe = 0;
        #2;
        reset = 1'b1;
        @(negedge clock);
        chk("rel_ready", din.ready, 1);
        chk("rel_a_size", a_size, 0);
        chk("rel_b_size", b_size, 0);
        chk("rel_start", start, 0);
        @(posedge clock);
        #1;
    endtask

    task automatic check_issue();
        @(negedge clock);
        chk("start", start, 1);
        chk("a_size", a_size, qa.size());
        chk("b_size", b_size, qb.size());
        chk("issue_ready", din.ready, 0);
        chk("overflow", overflow, exp_ovf);
        chk("order_error", order_error, exp_oe);
        chk("issue_a_valid", ca.valid, 0);
        chk("issue_a_data", ca.data, 0);
        @(posedge clock);
        #1;
    endtask

    // mode 1 holds chunk_a ready at 1,0,1 for the first three cycles.
    task automatic drain(int mode);
        int ia = 0;
        int ib = 0;
        int na = qa.size();
        int nb = qb.size();
        bit done = 0;
        bit ra;
        bit rb;
        bit eva;
        bit evb;
        for (int c = 0; c < 300; c++) begin
            if (mode == 1 && c < 3) ra = (c != 1);
            else ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            ca.ready = ra;
            cb.ready = rb;
            @(negedge clock);
            eva = (ia < na);
            evb = (ib < nb);
            chk("a_valid", ca.valid, eva);
            chk("b_valid", cb.valid, evb);
            if (eva) begin
                chk("a_word", {ca.data, ca.dest, ca.user}, qa[ia]);
                chk("a_tlast", ca.tlast, ia == na - 1);
            end
            if (evb) begin
                chk("b_word", {cb.data, cb.dest, cb.user}, qb[ib]);
                chk("b_tlast", cb.tlast, ib == nb - 1);
            end
            chk("drain_ready", din.ready, 0);
            chk("drain_start", start, 0);
            if (eva && ra) ia++;
            if (evb && rb) ib++;
            @(posedge clock);
            #1;
            if (ia == na && ib == nb) begin
                done = 1;
                break;
            end
        end
        ca.ready = 1'b0;
        cb.ready = 1'b0;
        if (!done) chk("drain_timeout", done, 1);
    endtask

    task automatic finish_pair();
        int na = qa.size();
        @(negedge clock);
        chk("post_a_valid", ca.valid, 0);
        chk("post_b_valid", cb.valid, 0);
        @(posedge clock);
        #1;
        merge_done = 1'b1;
        @(posedge clock);
        #1;
        merge_done = 1'b0;
        qa.delete();
        qb.delete();
        phase = 0;
        @(negedge clock);
        chk("done_ready", din.ready, 1);
        chk("hold_a_size", a_size, na);
        chk("done_a_valid", ca.valid, 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int r;
        int guard;
        din.valid = 1'b0;
        din.tlast = 1'b0;
        din.data = '0;
        din.dest = '0;
        din.user = '0;
        ca.ready = 1'b0;
        cb.ready = 1'b0;
        phase = 0;
        exp_ovf = 0;
        exp_oe = 0;

        @(posedge clock);
        #1;
        apply_reset();

        // Flush with nothing captured is ignored.
        idle(1, 0);

        // Runs {5,9,12} and {3,10}, chunk_a back-pressured 1,0,1.
        push(mk(16'd5), 0, 0);
        push(mk(16'd9), 0, 0);
        push(mk(16'd12), 1, 0);
        push(mk(16'd3), 0, 0);
        push(mk(16'd10), 1, 0);
        check_issue();
        drain(1);
        finish_pair();

        // Run {7,8} then flush with B empty.
        push(mk(16'd7), 0, 0);
        push(mk(16'd8), 1, 0);
        idle(1, 0);
        check_issue();
        drain(0);
        finish_pair();

        // Ten words without tlast: forced split 7/3, then flush.
        for (int i = 0; i < 10; i++) push(mk(16'(20 + i)), 0, 0);
        idle(1, 0);
        check_issue();
        drain(0);
        finish_pair();

        // Non-monotonic run {4,2,6}.
        apply_reset();
        push(mk(16'd4), 0, 0);
        push(mk(16'd2), 0, 0);
        chk("order_after_2", order_error, exp_oe);
        push(mk(16'd6), 1, 0);
        push(mk(16'd1), 1, 0);
        check_issue();
        drain(0);
        finish_pair();

        // Reset asserted mid-drain after one A word was read.
        push(mk(16'd1), 0, 0);
        push(mk(16'd2), 1, 0);
        push(mk(16'd3), 1, 0);
        check_issue();
        ca.ready = 1'b1;
        @(negedge clock);
        chk("mid_a_word0", {ca.data, ca.dest, ca.user}, qa[0]);
        @(posedge clock);
        #1;
        ca.ready = 1'b0;
        chk("mid_a_valid", ca.valid, 1);
        chk("mid_a_word1", {ca.data, ca.dest, ca.user}, qa[1]);
        apply_reset();

        // Random run pairs with idle gaps, flushes and stray merge_done.
        for (int p = 0; p < 30; p++) begin
            guard = 0;
            while (phase < 2 && guard < 100) begin
                r = $urandom_range(0, 9);
                guard++;
                if (r == 0) begin
                    idle(0, 1);
                end else if (r == 1 && (phase == 1 || qa.size() == 0)) begin
                    idle(1, 0);
                end else begin
                    push(mk(16'($urandom)), $urandom_range(0, 3) == 0,
                         phase == 1 && $urandom_range(0, 4) == 0);
                end
            end
            if (phase < 2) chk("fill_timeout", phase, 2);
            check_issue();
            drain(0);
            finish_pair();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/merge_chunk_feeder.md
Name: merge_chunk_feeder

Overview:
- Upstream stage of the sorter merging core. Captures two consecutive sorted runs from one AXI stream into internal buffers A and B, presents the run sizes with a one-cycle start pulse, then serves the runs as two independent AXI streams (stream_in_a / stream_in_b of the merger).
- Waits for merge_done before capturing the next pair, so one pair is in flight at a time.

Parameters:
- DATA_WIDTH, 32, width of data field
- DEST_WIDTH, 32, width of dest field
- USER_WIDTH, 32, width of user field
- MAX_SORT_LENGTH, 32, buffer depth; longest run is MAX_SORT_LENGTH-1 words

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- data_in  axi_stream.slave  intf  incoming runs; tlast marks last word of each run
- flush  input  1  pulse: close out an odd trailing run
- chunk_a  axi_stream.master  intf  run A output to merger
- chunk_b  axi_stream.master  intf  run B output to merger
- chunk_a_size  output  $clog2(MAX_SORT_LENGTH)  words in run A, held from start until next capture
- chunk_b_size  output  $clog2(MAX_SORT_LENGTH)  words in run B
- start  output  1  one-cycle pulse, sizes valid
- merge_done  input  1  pulse from merger, pair consumed
- overflow  output  1  sticky: a run was force-split
- order_error  output  1  sticky: non-monotonic run (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-low, also mid-operation): FSM to FILL_A; all pointers, sizes, start, overflow and order_error to 0; data_in.ready, chunk_a/b.valid and tlast to 0. Buffer contents are not cleared.
- FSM states: FILL_A, FILL_B, ISSUE, DRAIN.
- FILL_A:
  - data_in.ready=1.
  - Each handshake writes {data,dest,user} to buf_a[wr_ptr] and increments wr_ptr.
  - On a handshake with tlast: chunk_a_size <= wr_ptr+1, wr_ptr <= 0, go to FILL_B.
  - flush while wr_ptr==0: ignored.
- FILL_B:
  - Same capture into buf_b; tlast sets chunk_b_size and goes to ISSUE.
  - flush (no handshake that cycle) sets chunk_b_size <= wr_ptr and goes to ISSUE. With wr_ptr==0 this yields chunk_b_size=0.
  - A handshake and flush in the same cycle: the word is captured first; flush is then honoured only if that word carried tlast, otherwise flush is dropped.
- Forced split: a non-tlast word landing at index MAX_SORT_LENGTH-2 is treated as tlast and sets overflow.
- ISSUE: data_in.ready=0; start=1 for exactly one cycle; rd_ptr_a = rd_ptr_b = 0; go to DRAIN.
- DRAIN:
  - data_in.ready=0.
  - chunk_a.valid = (rd_ptr_a < chunk_a_size).
  - chunk_a.data/dest/user = buf_a[rd_ptr_a], combinational from registers, stable while valid.
  - chunk_a.tlast = valid & (rd_ptr_a == chunk_a_size-1).
  - chunk_a.valid & ready increments rd_ptr_a. chunk_b behaves identically.
  - merge_done goes to FILL_A and clears wr_ptr. Remaining unread words are discarded.
- Outside DRAIN, chunk_a.valid, chunk_b.valid, data and tlast are 0.
- merge_done outside DRAIN: ignored. start outside ISSUE: 0.
- Throughput: one input word per cycle while filling. Start is asserted 1 cycle after the last B word.
- All size arithmetic is unsigned, $clog2(MAX_SORT_LENGTH) bits; no wrap is possible because of the forced split.

Optional Feature:
- Macro: CHUNK_FEEDER_ORDER_CHECK_EN
- Defined:
  - In FILL_A/FILL_B, each accepted non-first word of a run is compared with the previous word.
  - data < previous sets order_error (sticky until reset).
  - Capture is unaffected.
- Undefined: no comparator or previous-word register; order_error tied to 0.

Test Plan:
- Run A {5,9,12} tlast, run B {3,10} tlast -> start pulse with chunk_a_size=3, chunk_b_size=2. chunk_a serves 5,9,12 with tlast on 12; chunk_b serves 3,10 with tlast on 10. Ready held 0 until merge_done; after merge_done, FILL_A and ready=1.
- Run A {7,8} tlast, then flush with B empty -> start with sizes 2/0; chunk_b.valid never asserted.
- MAX_SORT_LENGTH=8, 10-word run without tlast -> run A closed at 7 words, overflow=1, remaining 3 words go to B; flush -> sizes 7/3.
- Reset deasserted-to-asserted during DRAIN with rd_ptr_a=1 -> all valids 0 immediately (async). After release: FILL_A, sizes 0, start 0.
- With CHUNK_FEEDER_ORDER_CHECK_EN defined, run {4,2,6} -> order_error=1 after word 2, data still served as 4,2,6. Without the macro, order_error stays 0.
- Merger back-pressure: chunk_a.ready toggles 1,0,1 -> data held stable while ready=0, no word skipped or duplicated.
